// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: FSM states, per-stage hold
// patterns and the Stop/NoStop levels understood by the pipeline registers.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } stall_state_e;

    localparam int STALL_W = 6;

    // Bit positions inside the stall vector
    localparam int PC_BIT  = 0;
    localparam int IF_BIT  = 1;
    localparam int ID_BIT  = 2;
    localparam int EX_BIT  = 3;
    localparam int MEM_BIT = 4;
    localparam int WB_BIT  = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int WAIT_W = 10;

endpackage : pipe_stall_ctrl_pkg

// File: rtl/pipe_stall_ctrl_counter.sv
// stall_sat_counter: saturating up-counter with synchronous clear that wins over
// increment; counts stall cycles for performance monitoring.
module stall_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : stall_sat_counter

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges decode/execute hazards with divide and memory
// waits into per-stage holds. Optional watchdog enabled by STALL_WATCHDOG_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_id,
    input  logic                 stallreq_ex,
    input  logic                 div_start,
    input  logic                 div_ready,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    input  logic                 clr_cnt,
    output logic [STALL_W-1:0]   stall,
    output logic                 busy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 timeout_err
);

    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("pipe_stall_ctrl: TIMEOUT out of range 2..1023");
    end

    stall_state_e r_state;
    stall_state_e w_state_nxt;
    logic         r_busy;
    logic         w_mem_src;
    logic         w_ex_src;
    logic         w_id_src;
    logic         w_wd_fire;
    logic         w_cnt_inc;

    // Request sources; the ack in the current cycle releases its own source
    assign w_mem_src = ((r_state == MEM_WAIT) && !mem_ack) ||
                       ((r_state == IDLE) && mem_req && !mem_ack);
    assign w_ex_src  = ((r_state == DIV_WAIT) && !div_ready) ||
                       ((r_state == IDLE) && div_start && !div_ready) ||
                       stallreq_ex;
    assign w_id_src  = stallreq_id;

    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            stall = STALL_NONE;
        end else if (w_mem_src) begin
            stall = STALL_MEM;
        end else if (w_ex_src) begin
            stall = STALL_EX;
        end else if (w_id_src) begin
            stall = STALL_ID;
        end
    end

`ifdef STALL_WATCHDOG_EN
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;
    logic              w_wait_ack;

    assign w_wait_ack = ((r_state == DIV_WAIT) && div_ready) ||
                        ((r_state == MEM_WAIT) && mem_ack);
    assign w_wd_fire  = (r_state != IDLE) && !w_wait_ack &&
                        (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Held at zero in IDLE so every wait starts counting from zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_wd_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    w_state_nxt = MEM_WAIT;
                end else if (div_start && !div_ready) begin
                    w_state_nxt = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (div_ready || w_wd_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            MEM_WAIT: begin
                if (mem_ack || w_wd_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign busy      = r_busy;
    assign w_cnt_inc = (stall[PC_BIT] == Stop);

    stall_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_cnt_inc),
        .i_clr   (clr_cnt),
        .o_cnt   (stall_cnt)
    );

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios then random traffic, all checked
// against a transaction-level reference model of outstanding waits.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef STALL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, stallreq_id, stallreq_ex, div_start, div_ready;
    logic             mem_req, mem_ack, clr_cnt;
    logic [5:0]       stall;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which access is outstanding (none/div/mem) and its age
    typedef enum int {M_NONE, M_DIV, M_MEM} pend_e;
    pend_e m_pend = M_NONE;
    int    m_age  = 0;
    int    m_cnt  = 0;
    bit    m_terr = 1'b0;

    pipe_stall_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .div_start   (div_start),
        .div_ready   (div_ready),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .clr_cnt     (clr_cnt),
        .stall       (stall),
        .busy        (busy),
        .stall_cnt   (stall_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_stall();
        bit mem_hold, ex_hold;
        if (!rst) return 6'b000000;
        mem_hold = (m_pend == M_MEM && !mem_ack) || (m_pend == M_NONE && mem_req && !mem_ack);
        ex_hold  = (m_pend == M_DIV && !div_ready) || (m_pend == M_NONE && div_start && !div_ready)
                   || stallreq_ex;
        if (mem_hold) return 6'b011111;
        if (ex_hold) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    // One clock: drive at negedge, check mid-cycle, advance model at posedge
    task automatic step(input bit r, input bit id, input bit ex, input bit ds, input bit dr,
                        input bit mr, input bit ma, input bit clr);
        logic [5:0] exp_stall;
        @(negedge clk);
        rst = r; stallreq_id = id; stallreq_ex = ex; div_start = ds; div_ready = dr;
        mem_req = mr; mem_ack = ma; clr_cnt = clr;
        #1;
        exp_stall = model_stall();
        check("stall", 32'(stall), 32'(exp_stall));
        check("busy", 32'(busy), rst ? 32'(m_pend != M_NONE) : 32'd0);
        check("stall_cnt", 32'(stall_cnt), rst ? 32'(m_cnt) : 32'd0);
        check("timeout_err", 32'(timeout_err), rst ? 32'(m_terr) : 32'd0);
        @(posedge clk);
        if (!rst) begin
            m_pend = M_NONE; m_age = 0; m_cnt = 0; m_terr = 1'b0;
        end else begin
            if (clr) m_cnt = 0;
            else if (exp_stall[0] && m_cnt < CNT_MAX) m_cnt++;
            case (m_pend)
                M_NONE: begin
                    if (mr && !ma) begin m_pend = M_MEM; m_age = 0; end
                    else if (ds && !dr) begin m_pend = M_DIV; m_age = 0; end
                end
                default: begin
                    if ((m_pend == M_MEM && ma) || (m_pend == M_DIV && dr)) begin
                        m_pend = M_NONE;
                    end else if (WD && m_age == TIMEOUT - 1) begin
                        m_pend = M_NONE; m_terr = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
            endcase
        end
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0; stallreq_id = 1'b1; stallreq_ex = 1'b1; div_start = 1'b1; div_ready = 1'b0;
        mem_req = 1'b1; mem_ack = 1'b0; clr_cnt = 1'b0;
        // Reset with requests active: outputs must stay quiet
        step(0, 1, 1, 1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        idle_n(2);

        // Decode hazard for three cycles
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_n(1);
        check("id_cnt3", 32'(stall_cnt), 32'd3);
        step(1, 0, 0, 0, 0, 0, 0, 1);

        // Divide with ready after five cycles
        step(1, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        idle_n(1);
        check("div_cnt5", 32'(stall_cnt), 32'd5);
        step(1, 0, 0, 0, 0, 0, 0, 1);

        // mem_req and div_start together, ack after two cycles; then ex during mem wait
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        idle_n(2);

        // Memory access with no ack: watchdog decides whether it is abandoned
        step(1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle_n(2);
        check("terr_sticky", 32'(timeout_err), 32'(WD));
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Ack in the eighth wait cycle exits normally
        step(1, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        idle_n(2);
        check("terr_ack_win", 32'(timeout_err), 32'd0);

        // Reset in the third divide wait cycle
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle_n(2);

        // Long stall saturates the 4-bit counter
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_n(1);
        check("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
        step(1, 1, 0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 30) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
